// File: rtl/fetch_prefetch_queue_pkg.sv
// Shared core definitions for the RV32I front end: datapath width, reset PC
// and the canonical NOP used by fetch and the hazard unit's bubbles.
package fetch_prefetch_queue_pkg;

  localparam int CORE_XLEN = 32;
  localparam logic [CORE_XLEN-1:0] CORE_RESET_PC = 32'h0000_0000;

  // addi x0, x0, 0
  localparam logic [31:0] RV_NOP = 32'h0000_0013;

  typedef logic [31:0] instr_t;

endpackage

// File: rtl/fetch_prefetch_queue_ram.sv
// Prefetch queue storage: DEPTH x WIDTH register array, one write port and
// one asynchronous read port. Contents are deliberately left unreset.
module prefetch_ram
  import fetch_prefetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32 + CORE_XLEN,
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [PW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_reg [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_reg[waddr] <= wdata;
    end
  end

  // Combinational read so the head is visible the cycle after it is written.
  assign rdata = mem_reg[raddr];

endmodule

// File: rtl/fetch_prefetch_queue.sv
// Instruction-fetch front end: runs the fetch PC, buffers up to DEPTH fetched
// {pc, instr} pairs and hands them to decode; a redirect flushes and restarts.
module fetch_prefetch_queue
  import fetch_prefetch_queue_pkg::*;
#(
  parameter int              XLEN     = CORE_XLEN,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(CORE_RESET_PC)
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     ireq,
  output logic [XLEN-1:0]          iaddr,
  input  logic [31:0]              idata,
  input  logic                     iready_n,
  input  logic                     redirect,
  input  logic [XLEN-1:0]          redirect_pc,
  output logic                     deq_valid,
  input  logic                     deq_ready,
  output logic [31:0]              deq_instr,
  output logic [XLEN-1:0]          deq_pc,
  output logic [XLEN-1:0]          deq_pcp4,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = 32 + XLEN;

  logic [XLEN-1:0] fpc_reg, fpc_next;
  logic [PW-1:0]   wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0]   rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0]   count_reg, count_next;

  logic            not_empty;
  logic            fetch_fire;
  logic            pop_fire;
  logic [EW-1:0]   head_entry;
  logic [XLEN-1:0] head_pc;
  logic [31:0]     head_instr;

  assign not_empty  = (count_reg != '0);
  assign ireq       = !redirect && (count_reg < CW'(DEPTH));
  assign fetch_fire = ireq && !iready_n;
  assign deq_valid  = not_empty && !redirect;
  assign pop_fire   = deq_valid && deq_ready;

  prefetch_ram #(
    .DEPTH (DEPTH),
    .WIDTH (EW),
    .PW    (PW)
  ) u_ram (
    .clk   (clk),
    .we    (fetch_fire),
    .waddr (wr_ptr_reg),
    .wdata ({fpc_reg, idata}),
    .raddr (rd_ptr_reg),
    .rdata (head_entry)
  );

  assign head_pc    = head_entry[EW-1:32];
  assign head_instr = head_entry[31:0];

  // Storage is never cleared, so stale slots are hidden behind count.
  assign iaddr     = fpc_reg;
  assign count     = count_reg;
  assign deq_instr = not_empty ? head_instr : RV_NOP;
  assign deq_pc    = not_empty ? head_pc : '0;
  assign deq_pcp4  = not_empty ? head_pc + XLEN'(4) : '0;

  always_comb begin
    fpc_next    = fpc_reg;
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (redirect) begin
      // Both fires are already masked by redirect, so nothing else moves.
      fpc_next    = redirect_pc & ~XLEN'(3);
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (fetch_fire) begin
        wr_ptr_next = wr_ptr_reg + PW'(1);
        fpc_next    = fpc_reg + XLEN'(4);
      end
      if (pop_fire) begin
        rd_ptr_next = rd_ptr_reg + PW'(1);
      end
      case ({fetch_fire, pop_fire})
        2'b10:   count_next = count_reg + CW'(1);
        2'b01:   count_next = count_reg - CW'(1);
        default: count_next = count_reg;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fpc_reg    <= RESET_PC;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      fpc_reg    <= fpc_next;
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

endmodule

// File: doc/fetch_prefetch_queue.md
# fetch_prefetch_queue

Parametrised instruction-fetch front end for the pipelined RV32I core. It replaces the single-register fetch stage with a DEPTH-entry prefetch queue. It runs a fetch PC, and accepts an instruction from the instruction bus whenever `iready_n` is low and a slot is free. Decode pops entries with a valid/ready handshake; a branch redirect flushes the queue and restarts fetch at the target.

## Interface
- `XLEN`, 32: address/PC width.
- `DEPTH`, 4: queue entries; power of two, ≥2.
- `RESET_PC`, 32'h0000_0000: fetch PC after reset; bits [1:0] must be 0.
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `ireq` out 1: fetch request this cycle.
- `iaddr` out XLEN: fetch address, always equal to the fetch PC.
- `idata` in 32: instruction for `iaddr`, valid when `iready_n`=0.
- `iready_n` in 1: active-low instruction-bus ready.
- `redirect` in 1: flush and restart fetch.
- `redirect_pc` in XLEN: new fetch PC; bits [1:0] ignored (forced 0).
- `deq_valid` out 1: head entry valid.
- `deq_ready` in 1: decode accepts head entry.
- `deq_instr` out 32: head instruction; 32'h0000_0013 (NOP) when empty.
- `deq_pc` out XLEN: head PC; 0 when empty.
- `deq_pcp4` out XLEN: head PC+4; 0 when empty.
- `count` out $clog2(DEPTH)+1: occupied entries.

## Operation
- State: `fpc`, `wr_ptr`, `rd_ptr` (each $clog2(DEPTH) bits, wrap modulo DEPTH), and `count`.
- `ireq` = !`redirect` && `count`<DEPTH. Full blocks fetch even if a pop occurs in the same cycle; there is no pop/push bypass.
- Fetch fire = `ireq` && !`iready_n`. On fetch fire:
  - store {`fpc`, `idata`} at `wr_ptr`;
  - `wr_ptr`++;
  - `fpc` += 4, wrapping modulo 2^XLEN.
- Pop fire = `deq_valid` && `deq_ready`. On pop fire, `rd_ptr`++.
- `count` next = `count` + fetch fire − pop fire. Simultaneous fire leaves `count` unchanged.
- `deq_valid` = (`count`≠0) && !`redirect`. Head outputs are read from storage at `rd_ptr`; `deq_pcp4` = `deq_pc`+4.
- Redirect has priority over everything:
  - next cycle `count`=0, both pointers 0, `fpc`={`redirect_pc`[XLEN-1:2],2'b00};
  - a fetch or pop in the redirect cycle is discarded and has no effect.
- Back-to-back redirects: the last one wins.
- Reset (asynchronous, also mid-operation): `fpc`=RESET_PC, pointers 0, `count`=0, `deq_valid`=0, `deq_instr`=NOP, `deq_pc`/`deq_pcp4`=0. `ireq` is 1 once `rst` deasserts.
- Storage contents are not reset. Outputs are masked by `count`=0.

## Timing
- Fetch-to-decode latency: an instruction fetched in cycle N is visible at the head in cycle N+1 at the earliest.
- Sustained throughput: one instruction per cycle with `iready_n`=0 and `deq_ready`=1.
- Redirect asserted in cycle N: `iaddr`=target in cycle N+1. The target instruction is at the head in N+2 at the earliest.
- `iready_n` high stalls fetch only. Queued entries keep draining.
- `deq_ready` low holds head outputs stable. The queue fills to DEPTH, then `ireq` drops and `iaddr` holds.
- Outputs `iaddr`, `ireq`, and `deq_*` depend only on registers, plus the `redirect` masking on `ireq` and `deq_valid`.

## Structure
- Shared core package: `XLEN`, the default `RESET_PC`, and `RV_NOP` = 32'h0000_0013. The hazard unit's bubble insertion uses the same `RV_NOP`.
- Sub-module `prefetch_ram`: a DEPTH × (32+XLEN) register array with one write port and one asynchronous read port. Pointer, count and PC logic stay in the top module.

## Test plan
- Reset, then `iready_n`=0 and `deq_ready`=1 held, with `idata` = PC-derived:
  - head in cycle 2 is PC 0x0;
  - then 0x4, 0x8, … one per cycle; `count` stays 1.
- `deq_ready`=0, `iready_n`=0:
  - `count` reaches 4 after 4 cycles;
  - `ireq` drops and `iaddr` holds 0x10;
  - releasing `deq_ready` drains PCs 0x0–0xC in order.
- Full queue with `deq_ready`=1 for one cycle:
  - `count` goes 4→3;
  - no fetch in that cycle;
  - fetch of 0x10 in the next cycle.
- Redirect to 0x0000_0103 with 3 entries queued and a fetch firing in the same cycle:
  - next cycle `count`=0, `deq_valid`=0, `iaddr`=0x0000_0100;
  - the discarded fetch never appears at the head.
- `iready_n` toggling 0/1 every cycle with `deq_ready`=1: the head shows sequential PCs with bubbles (`deq_valid`=0) on the missing cycles, and no PC is skipped or duplicated.
- `rst` pulsed mid-stream with `count`=2:
  - immediately `deq_valid`=0, `deq_instr`=0x0000_0013, `iaddr`=RESET_PC;
  - fetch resumes at RESET_PC after deassertion.
